// File: rtl/eeprom_pkg.sv
// Shared types and default timing for the EEPROM bus arbiter.
// Timing defaults are in clk cycles; the widths match an 8Kx8 part.
package eeprom_pkg;

   localparam int ADDR_W_DEF      = 13;
   localparam int DATA_W_DEF      = 8;
   localparam int READ_WAIT_DEF   = 4;
   localparam int WE_PULSE_DEF    = 5000;
   localparam int WRITE_CYCLE_DEF = 500000;
   localparam int CNT_W_DEF       = 24;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      RD_ACC   = 3'd2,
      WR_PULSE = 3'd3,
      WR_HOLD  = 3'd4,
      WR_BUSY  = 3'd5
   } state_t;

endpackage

// File: rtl/eeprom_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick. When both ports ask, the port that did not
// win last time gets the grant.
module eeprom_rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_port
);

   assign grant_valid = req0 | req1;
   assign grant_port  = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/eeprom_bus_arbiter.sv
// Shares one parallel EEPROM between a CPU read port (0) and a loader port (1),
// sequencing address setup, OE access, WE pulse and the internal write cycle.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no transaction; arbitrate req0/req1 and latch the winner
// SETUP    | address/data valid on the pins, strobes low
// RD_ACC   | OE high for READ_WAIT cycles; DQ sampled on the last one
// WR_PULSE | WE high for WE_PULSE cycles with data driven
// WR_HOLD  | WE low, data and address still driven for hold time
// WR_BUSY  | bus quiet while the part completes its internal write
module eeprom_bus_arbiter
   import eeprom_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int READ_WAIT   = READ_WAIT_DEF,
   parameter int WE_PULSE    = WE_PULSE_DEF,
   parameter int WRITE_CYCLE = WRITE_CYCLE_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              done0,
   output logic              done1,
   output logic              busy0,
   output logic              busy1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ee_addr,
   output logic [DATA_W-1:0] ee_dout,
   output logic              ee_dq_oe,
   input  logic [DATA_W-1:0] ee_din,
   output logic              ee_oe,
   output logic              ee_we
);

   localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] T_READ  = CNT_W'(READ_WAIT);
   localparam logic [CNT_W-1:0] T_PULSE = CNT_W'(WE_PULSE);
   localparam logic [CNT_W-1:0] T_WCYC  = CNT_W'(WRITE_CYCLE);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  timer, timer_nxt;
   logic              tc;
   logic              last_grant, last_grant_nxt;
   logic              cur_port, cur_port_nxt;
   logic              cur_we, cur_we_nxt;
   logic              gnt_valid, gnt_port, take;

   logic              done0_nxt, done1_nxt, busy0_nxt, busy1_nxt;
   logic              ee_oe_nxt, ee_we_nxt, ee_dq_oe_nxt;
   logic [ADDR_W-1:0] ee_addr_nxt;
   logic [DATA_W-1:0] ee_dout_nxt, rdata_nxt;

   eeprom_rr_arb2 u_arb (
      .req0        (req0),
      .req1        (req1),
      .last_grant  (last_grant),
      .grant_valid (gnt_valid),
      .grant_port  (gnt_port)
   );

   assign tc   = (timer == T_ONE);
   assign take = (state == IDLE) && gnt_valid;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         timer      <= '0;
         last_grant <= 1'b1;
         cur_port   <= 1'b0;
         cur_we     <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         busy0      <= 1'b0;
         busy1      <= 1'b0;
         rdata      <= '0;
         ee_addr    <= '0;
         ee_dout    <= '0;
         ee_dq_oe   <= 1'b0;
         ee_oe      <= 1'b0;
         ee_we      <= 1'b0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         last_grant <= last_grant_nxt;
         cur_port   <= cur_port_nxt;
         cur_we     <= cur_we_nxt;
         done0      <= done0_nxt;
         done1      <= done1_nxt;
         busy0      <= busy0_nxt;
         busy1      <= busy1_nxt;
         rdata      <= rdata_nxt;
         ee_addr    <= ee_addr_nxt;
         ee_dout    <= ee_dout_nxt;
         ee_dq_oe   <= ee_dq_oe_nxt;
         ee_oe      <= ee_oe_nxt;
         ee_we      <= ee_we_nxt;
      end
   end

   // Timer is reloaded whenever the state changes; terminal count is 1.
   always_comb begin
      state_nxt = state;
      timer_nxt = (timer != '0) ? timer - T_ONE : timer;
      case (state)
         IDLE:     if (gnt_valid) state_nxt = SETUP;
         SETUP:    state_nxt = cur_we ? WR_PULSE : RD_ACC;
         RD_ACC:   if (tc) state_nxt = IDLE;
         WR_PULSE: if (tc) state_nxt = WR_HOLD;
         WR_HOLD:  state_nxt = WR_BUSY;
         WR_BUSY:  if (tc) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
      if (state_nxt != state) begin
         case (state_nxt)
            SETUP:    timer_nxt = T_ONE;
            RD_ACC:   timer_nxt = T_READ;
            WR_PULSE: timer_nxt = T_PULSE;
            WR_HOLD:  timer_nxt = T_ONE;
            WR_BUSY:  timer_nxt = T_WCYC;
            default:  timer_nxt = '0;
         endcase
      end
   end

   // Register inputs are derived from the state being entered so that every
   // pin changes on the same edge as the state register.
   always_comb begin
      last_grant_nxt = last_grant;
      cur_port_nxt   = cur_port;
      cur_we_nxt     = cur_we;
      ee_addr_nxt    = ee_addr;
      ee_dout_nxt    = ee_dout;
      rdata_nxt      = rdata;
      if (take) begin
         last_grant_nxt = gnt_port;
         cur_port_nxt   = gnt_port;
         cur_we_nxt     = gnt_port ? we1 : we0;
         ee_addr_nxt    = gnt_port ? addr1 : addr0;
         ee_dout_nxt    = gnt_port ? wdata1 : wdata0;
      end
      if ((state == RD_ACC) && tc) rdata_nxt = ee_din;

      busy0_nxt    = (state_nxt != IDLE) && !cur_port_nxt;
      busy1_nxt    = (state_nxt != IDLE) &&  cur_port_nxt;
      done0_nxt    = (state_nxt == IDLE) && ((state == RD_ACC) || (state == WR_BUSY)) && !cur_port;
      done1_nxt    = (state_nxt == IDLE) && ((state == RD_ACC) || (state == WR_BUSY)) &&  cur_port;
      ee_oe_nxt    = (state_nxt == RD_ACC);
      ee_we_nxt    = (state_nxt == WR_PULSE);
      ee_dq_oe_nxt = ((state_nxt == SETUP) && cur_we_nxt) ||
                     (state_nxt == WR_PULSE) || (state_nxt == WR_HOLD);
   end

endmodule

// File: tb/tb_eeprom_bus_arbiter.sv
// Directed bench for eeprom_bus_arbiter with short timing parameters.
module tb_eeprom_bus_arbiter;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;
   localparam int RW     = 4;
   localparam int WP     = 5;
   localparam int WC     = 20;
   localparam int RD_LAT = RW + 2;
   localparam int WR_LAT = WP + WC + 3;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic done0, done1, busy0, busy1, ee_dq_oe, ee_oe, ee_we;
   logic [DATA_W-1:0] rdata, ee_dout, ee_din;
   logic [ADDR_W-1:0] ee_addr;
   logic [DATA_W-1:0] din_val = '0;

   int tests_run = 0;
   int tests_failed = 0;

   // Part only drives DQ while OE is asserted; early sampling reads 0.
   assign ee_din = ee_oe ? din_val : '0;

   always #5 clk = ~clk;

   eeprom_bus_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(RW),
      .WE_PULSE(WP), .WRITE_CYCLE(WC), .CNT_W(24)
   ) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .busy0(busy0), .busy1(busy1),
      .rdata(rdata), .ee_addr(ee_addr), .ee_dout(ee_dout), .ee_dq_oe(ee_dq_oe),
      .ee_din(ee_din), .ee_oe(ee_oe), .ee_we(ee_we)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   // Bus invariants and one-cycle done pulses, checked every cycle.
   logic prev_d0 = 1'b0, prev_d1 = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         tests_run++;
         if ((ee_we && ee_oe) || (busy0 && busy1) || (ee_dq_oe && ee_oe) ||
             (done0 && prev_d0) || (done1 && prev_d1)) begin
            tests_failed++;
            $display("FAIL invariant at %0t: we=%0b oe=%0b dq_oe=%0b busy=%0b%0b done=%0b%0b prev_done=%0b%0b, expected no overlap",
                     $time, ee_we, ee_oe, ee_dq_oe, busy1, busy0, done1, done0, prev_d1, prev_d0);
         end
      end
      prev_d0 = done0;
      prev_d1 = done1;
   end

   typedef struct {
      bit                port;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [DATA_W-1:0] din;
      int                exp_lat;
   } txn_t;

   task automatic run_txn(input int idx, input txn_t t);
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      din_val = t.din;
      if (t.port) begin req1 = 1'b1; we1 = t.we; addr1 = t.addr; wdata1 = t.wdata; end
      else        begin req0 = 1'b1; we0 = t.we; addr0 = t.addr; wdata0 = t.wdata; end
      while (!seen && n < 100) begin
         step();
         n++;
         if (n == 1) begin
            req0 = 1'b0;
            req1 = 1'b0;
            check($sformatf("vec%0d addr", idx), ee_addr, t.addr);
            check($sformatf("vec%0d busy", idx), {busy1, busy0}, t.port ? 2'b10 : 2'b01);
            check($sformatf("vec%0d dq_oe", idx), ee_dq_oe, t.we);
            if (t.we) check($sformatf("vec%0d dout", idx), ee_dout, t.wdata);
         end
         if (t.port ? done1 : done0) seen = 1'b1;
      end
      check($sformatf("vec%0d latency", idx), n, t.exp_lat);
      if (!t.we) check($sformatf("vec%0d rdata", idx), rdata, t.din);
   endtask

   txn_t tv[5];

   initial begin
      int bad;
      int done_k;
      int cnt;
      int order[4];
      bit checked_sw;

      tv[0] = '{0, 0, 13'h0000, 8'h00, 8'hA5, RD_LAT};
      tv[1] = '{1, 0, 13'h1FFF, 8'h00, 8'h3C, RD_LAT};
      tv[2] = '{0, 1, 13'h1FFF, 8'hFF, 8'h00, WR_LAT};
      tv[3] = '{1, 1, 13'h0000, 8'h00, 8'h00, WR_LAT};
      tv[4] = '{0, 0, 13'h0AAA, 8'h00, 8'hFF, RD_LAT};

      do_reset();
      check("reset outs", {done0, done1, busy0, busy1, ee_oe, ee_we, ee_dq_oe}, 7'b0);
      check("reset rdata", rdata, 8'h00);
      check("reset ee_addr", ee_addr, 13'h0);

      // Single read on port 0, cycle by cycle.
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h1ABC; din_val = 8'h5A;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (k == 1) begin
            req0 = 1'b0;
            check("read addr", ee_addr, 13'h1ABC);
         end
         check($sformatf("read cyc%0d {oe,we,done0,busy0}", k), {ee_oe, ee_we, done0, busy0},
               {(k >= 2 && k <= 5), 1'b0, (k == 6), (k >= 1 && k <= 5)});
      end
      check("read rdata", rdata, 8'h5A);

      // Single write on port 1, cycle by cycle.
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0010; wdata1 = 8'hC3;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 1) req1 = 1'b0;
         check($sformatf("write cyc%0d {we,dq_oe,busy1,done1}", k), {ee_we, ee_dq_oe, busy1, done1},
               {(k >= 2 && k <= 6), (k >= 1 && k <= 7), (k >= 1 && k <= 27), (k == 28)});
         if (k <= 7) check($sformatf("write cyc%0d dout", k), ee_dout, 8'hC3);
      end
      check("write keeps rdata", rdata, 8'h5A);

      for (int i = 0; i < 5; i++) run_txn(i, tv[i]);

      // Inputs change after grant: address and request are ignored.
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0010; wdata1 = 8'h77;
      bad = 0;
      done_k = 0;
      for (int k = 1; k <= 30; k++) begin
         step();
         if (k == 3) begin addr1 = 13'h0FFF; req1 = 1'b0; end
         if (k <= 27 && ee_addr !== 13'h0010) bad++;
         if (done1 && done_k == 0) done_k = k;
      end
      check("midop addr held", bad, 0);
      check("midop done1 cycle", done_k, 28);

      // Contention from reset: both ports read continuously.
      do_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0100;
      req1 = 1'b1; we1 = 1'b0; addr1 = 13'h0200;
      din_val = 8'h11;
      cnt = 0;
      checked_sw = 1'b0;
      for (int k = 1; k <= 60 && cnt < 4; k++) begin
         step();
         if (cnt == 1 && order[0] == 0 && !checked_sw) begin
            checked_sw = 1'b1;
            check("contention switch busy1", {busy1, busy0}, 2'b10);
            check("contention switch addr", ee_addr, 13'h0200);
         end
         if (done0 || done1) begin
            order[cnt] = done1 ? 1 : 0;
            cnt++;
         end
      end
      check("contention grants", cnt, 4);
      for (int i = 0; i < 4; i++) check($sformatf("contention order%0d", i), order[i], i % 2);
      req0 = 1'b0; req1 = 1'b0;

      // Reset in the middle of a write pulse.
      do_reset();
      req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0010; wdata1 = 8'hC3;
      step();
      req1 = 1'b0;
      step();
      step();
      step();
      check("pre-reset ee_we", ee_we, 1'b1);
      reset = 1'b0;
      step();
      check("abort {we,dq_oe,busy1,done1}", {ee_we, ee_dq_oe, busy1, done1}, 4'b0);
      reset = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0333;
      req1 = 1'b1; we1 = 1'b0; addr1 = 13'h0444;
      din_val = 8'h96;
      step();
      req0 = 1'b0; req1 = 1'b0;
      check("post-reset grant", {busy1, busy0}, 2'b01);
      check("post-reset addr", ee_addr, 13'h0333);
      bad = 0;
      done_k = 0;
      for (int k = 2; k <= 30; k++) begin
         step();
         if (done1) bad++;
         if (done0 && done_k == 0) done_k = k;
      end
      check("no done1 after abort", bad, 0);
      check("post-reset done0 cycle", done_k, RD_LAT);
      check("post-reset rdata", rdata, 8'h96);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/eeprom_bus_arbiter.md
Name: eeprom_bus_arbiter

Overview:
Shares one parallel 8Kx8 EEPROM between two requesters: port 0 (CPU fetch/read path) and port 1 (programmer/loader). It uses a round-robin grant and sequences the EEPROM bus timing: address setup, OE access window, WE pulse width, and the internal write-cycle wait. Each port sees a simple req/done handshake. The block sits between the CPU/loader logic and the EEPROM pins.

Parameters:
ADDR_W, 13, EEPROM address width
DATA_W, 8, EEPROM data width
READ_WAIT, 4, cycles OE held before read data is sampled (>=1)
WE_PULSE, 5000, cycles WE held high per write (>=1)
WRITE_CYCLE, 500000, cycles of internal write-cycle wait after WE drops (>=1)
CNT_W, 24, timer width; must hold max(READ_WAIT, WE_PULSE, WRITE_CYCLE)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-low
req0, req1  in  1  transaction request, level, per port
we0, we1  in  1  1=write, 0=read; valid while reqN high
addr0, addr1  in  ADDR_W  transaction address
wdata0, wdata1  in  DATA_W  write data
done0, done1  out  1  one-cycle completion pulse
busy0, busy1  out  1  port N transaction in progress
rdata  out  DATA_W  last read data, shared by both ports
ee_addr  out  ADDR_W  EEPROM address
ee_dout  out  DATA_W  EEPROM write data
ee_dq_oe  out  1  drive ee_dout onto DQ pins
ee_din  in  DATA_W  EEPROM DQ read back
ee_oe  out  1  EEPROM output enable, active-high
ee_we  out  1  EEPROM write enable, active-high

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, all outputs 0, rdata=0, timer=0, last_grant=1 so port 0 wins first. A transaction in flight is aborted: ee_we/ee_oe drop at that edge and no done is pulsed.
- All outputs are registered.
- IDLE: sample req0/req1.
  - If exactly one is high, grant it.
  - If both are high, grant the port opposite last_grant.
  - On grant: latch addr/we/wdata of the granted port, set last_grant, set busyN=1, go to SETUP.
- SETUP (1 cycle): ee_addr and ee_dout valid. ee_dq_oe=we. ee_oe=0, ee_we=0.
  - Read goes to RD_ACC; write goes to WR_PULSE.
- RD_ACC (READ_WAIT cycles): ee_oe=1.
  - On the last cycle, rdata<=ee_din.
  - Then go to IDLE with ee_oe=0 and doneN=1 for one cycle.
  - busyN clears with done.
- WR_PULSE (WE_PULSE cycles): ee_we=1, ee_dq_oe=1.
- WR_HOLD (1 cycle): ee_we=0. ee_dq_oe and ee_addr held for data hold time.
- WR_BUSY (WRITE_CYCLE cycles): ee_dq_oe=0, ee_oe=0, no bus activity.
  - Then go to IDLE with doneN=1 for one cycle.
- Latency from the IDLE cycle that samples req (cycle 0):
  - read: done at cycle READ_WAIT+2
  - write: done at cycle WE_PULSE+WRITE_CYCLE+3
- Handshake:
  - Inputs are latched at grant, so later changes to reqN/addrN/wdataN are ignored.
  - Deasserting reqN mid-transaction does not abort it; done is still pulsed.
  - If reqN is still high in the IDLE cycle where done pulses, it is taken as a new request. The round-robin then favours the other port if that port is requesting.
- Never more than one of busy0/busy1 high. ee_we and ee_oe are never high together. ee_dq_oe is never high while ee_oe is high.
- Timer: a single down-counter reloaded on each state entry. Terminal count is 1, so each phase lasts exactly its parameter count.
- Address wrap: none. The address is passed through unchanged.

Decomposition:
- Package eeprom_pkg holds:
  - state encodings: IDLE, SETUP, RD_ACC, WR_PULSE, WR_HOLD, WR_BUSY
  - default timing constants: READ_WAIT, WE_PULSE, WRITE_CYCLE
  - ADDR_W/DATA_W defaults
- One sub-module, eeprom_rr_arb2: combinational 2-way round-robin select from req0, req1 and last_grant. The FSM, timer and bus registers stay in the top.

Test Plan (bench overrides READ_WAIT=4, WE_PULSE=5, WRITE_CYCLE=20):
- Single read: req0=1, we0=0, addr0=0x1ABC, model returns 0x5A -> ee_addr=0x1ABC from cycle 1, ee_oe high cycles 2-5, done0 at cycle 6, rdata=0x5A, ee_we stays 0.
- Single write: req1=1, we1=1, addr1=0x0010, wdata1=0xC3 -> ee_we high cycles 2-6, ee_dout=0xC3 with ee_dq_oe high cycles 1-7, done1 at cycle 28, busy1 high cycles 1-27.
- Contention: req0 and req1 both held high with reads from reset -> grants alternate 0,1,0,1. The second grant starts SETUP in the cycle after done0.
- Input change mid-op: during a port-1 write, change addr1 to 0x0FFF and drop req1 at cycle 3 -> ee_addr stays 0x0010, done1 still pulses at cycle 28.
- Reset mid-write: reset=0 at cycle 4 -> next edge ee_we=0, busy1=0, no done1; the subsequent req0 read is granted first.
- Assertions throughout: !(ee_we && ee_oe), !(busy0 && busy1), done pulses exactly one cycle.
